// File: rtl/piso_stream_if.sv
// Handshake bundle for piso_stream: parallel word input and serial bit output.
interface piso_stream_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_out;
    logic             ser_first;
    logic             ser_last;

    modport master (
        output in_valid, in_data, ser_ready,
        input  in_ready, ser_valid, ser_out, ser_first, ser_last
    );

    modport slave (
        input  in_valid, in_data, ser_ready,
        output in_ready, ser_valid, ser_out, ser_first, ser_last
    );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out converter with a one-word holding buffer so that
// consecutive words stream with no bubble; selectable shift direction.
module piso_stream #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    output logic          busy,
    piso_stream_if.slave  s
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             act;
    logic             hold_v;
    logic             acc;
    logic             fire;
    logic             pop;

    assign acc  = s.in_valid && !hold_v;
    assign fire = act && s.ser_ready;
    assign pop  = fire && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sh     <= '0;
            hold   <= '0;
            cnt    <= '0;
            act    <= 1'b0;
            hold_v <= 1'b0;
        end else if (pop) begin
            // Word boundary: refill from hold first, then from the input port.
            cnt <= '0;
            if (hold_v) begin
                sh     <= hold;
                hold_v <= 1'b0;
            end else if (acc) begin
                sh <= s.in_data;
            end else begin
                act <= 1'b0;
            end
        end else begin
            if (fire) begin
                if (MSB_FIRST) sh <= {sh[WIDTH-2:0], 1'b0};
                else           sh <= {1'b0, sh[WIDTH-1:1]};
                cnt <= cnt + 1'b1;
            end
            if (acc) begin
                if (!act) begin
                    sh  <= s.in_data;
                    cnt <= '0;
                    act <= 1'b1;
                end else begin
                    hold   <= s.in_data;
                    hold_v <= 1'b1;
                end
            end
        end
    end

    assign s.in_ready  = !hold_v;
    assign s.ser_valid = act;
    assign s.ser_out   = act && (MSB_FIRST ? sh[WIDTH-1] : sh[0]);
    assign s.ser_first = act && (cnt == '0);
    assign s.ser_last  = act && (cnt == LAST);
    assign busy        = act || hold_v;
endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: a 4-bit MSB-first and an 8-bit LSB-first instance.
module tb_piso_stream;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic busy_a;
    logic busy_b;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [3:0] w4;
    logic [7:0] w8;
    logic [5:0] w6;

    piso_stream_if #(.WIDTH(4)) bus_a ();
    piso_stream_if #(.WIDTH(8)) bus_b ();

    piso_stream #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_a), .s(bus_a)
    );
    piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy_b), .s(bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ser_a(input string tag, input logic v, input logic o, input logic f, input logic l);
        chk({tag, "_valid"}, {7'b0, bus_a.ser_valid}, {7'b0, v});
        chk({tag, "_out"},   {7'b0, bus_a.ser_out},   {7'b0, o});
        chk({tag, "_first"}, {7'b0, bus_a.ser_first}, {7'b0, f});
        chk({tag, "_last"},  {7'b0, bus_a.ser_last},  {7'b0, l});
    endtask

    task automatic ser_b(input string tag, input logic v, input logic o, input logic f, input logic l);
        chk({tag, "_valid"}, {7'b0, bus_b.ser_valid}, {7'b0, v});
        chk({tag, "_out"},   {7'b0, bus_b.ser_out},   {7'b0, o});
        chk({tag, "_first"}, {7'b0, bus_b.ser_first}, {7'b0, f});
        chk({tag, "_last"},  {7'b0, bus_b.ser_last},  {7'b0, l});
    endtask

    task automatic idle_a(input string tag);
        ser_a(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_busy"},     {7'b0, busy_a},         8'd0);
        chk({tag, "_in_ready"}, {7'b0, bus_a.in_ready}, 8'd1);
    endtask

    initial begin
        bus_a.in_valid  = 1'b0;
        bus_a.in_data   = '0;
        bus_a.ser_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.in_data   = '0;
        bus_b.ser_ready = 1'b1;

        // reset values
        repeat (2) @(negedge clk);
        idle_a("rst_a");
        ser_b("rst_b", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_b_busy", {7'b0, busy_b}, 8'd0);
        chk("rst_b_in_ready", {7'b0, bus_b.in_ready}, 8'd1);
        rst_n = 1'b1;

        // single word, MSB first
        w4 = 4'b1011;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = w4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) bus_a.in_valid = 1'b0;
            ser_a("t1_bit", 1'b1, w4[3-i], i == 0, i == 3);
        end
        @(negedge clk);
        idle_a("t1_after");

        // back-to-back words through the hold buffer
        w8 = 8'hB6;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 4'hB;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ser_a("t2_bit", 1'b1, w8[7-i], (i % 4) == 0, (i % 4) == 3);
            chk("t2_in_ready", {7'b0, bus_a.in_ready}, {7'b0, (i == 0 || i >= 4)});
            if (i == 0) bus_a.in_data = 4'h6;
            if (i == 1) bus_a.in_valid = 1'b0;
        end
        @(negedge clk);
        idle_a("t2_after");

        // backpressure, hold full, third word refused
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 4'b1011;
        @(negedge clk);
        ser_a("t3_b1", 1'b1, 1'b1, 1'b1, 1'b0);
        bus_a.in_valid = 1'b0;
        @(negedge clk);
        ser_a("t3_b2", 1'b1, 1'b0, 1'b0, 1'b0);
        bus_a.ser_ready = 1'b0;
        bus_a.in_valid  = 1'b1;
        bus_a.in_data   = 4'h9;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ser_a("t3_stall", 1'b1, 1'b0, 1'b0, 1'b0);
            chk("t3_stall_in_ready", {7'b0, bus_a.in_ready}, 8'd0);
            chk("t3_stall_busy", {7'b0, busy_a}, 8'd1);
            if (k == 0) bus_a.in_data = 4'h3;
            if (k == 2) begin
                bus_a.ser_ready = 1'b1;
                bus_a.in_valid  = 1'b0;
            end
        end
        w6 = 6'b11_1001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ser_a("t3_rest", 1'b1, w6[5-i], i == 2, i == 1 || i == 5);
        end
        @(negedge clk);
        idle_a("t3_after");

        // LSB first, 8-bit word
        w8 = 8'hA5;
        bus_b.in_valid = 1'b1;
        bus_b.in_data  = w8;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) bus_b.in_valid = 1'b0;
            ser_b("t4_bit", 1'b1, w8[i], i == 0, i == 7);
        end
        @(negedge clk);
        ser_b("t4_after", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_after_busy", {7'b0, busy_b}, 8'd0);

        // clear with active word and full hold
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 4'hB;
        @(negedge clk);
        ser_a("t5_b1", 1'b1, 1'b1, 1'b1, 1'b0);
        bus_a.in_data = 4'h6;
        @(negedge clk);
        ser_a("t5_b2", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_hold_full", {7'b0, bus_a.in_ready}, 8'd0);
        @(negedge clk);
        ser_a("t5_b3", 1'b1, 1'b1, 1'b0, 1'b0);
        clear = 1'b1;
        @(negedge clk);
        idle_a("t5_cleared");
        clear = 1'b0;
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_quiet", {7'b0, bus_a.ser_valid}, 8'd0);
        end
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 4'hF;
        clear = 1'b1;
        @(negedge clk);
        idle_a("t5_clear_wins");
        clear = 1'b0;
        bus_a.in_valid = 1'b0;
        @(negedge clk);
        chk("t5_clear_wins_late", {7'b0, bus_a.ser_valid}, 8'd0);

        // reset mid-stream, then a clean word
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 4'hB;
        @(negedge clk);
        ser_a("t6_b1", 1'b1, 1'b1, 1'b1, 1'b0);
        bus_a.in_valid = 1'b0;
        @(negedge clk);
        ser_a("t6_b2", 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        idle_a("t6_rst");
        rst_n = 1'b1;
        w4 = 4'b0110;
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = w4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) bus_a.in_valid = 1'b0;
            ser_a("t6_bit", 1'b1, w4[3-i], i == 0, i == 3);
        end
        @(negedge clk);
        idle_a("t6_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised, handshaked parallel-in/serial-out converter for the decompressor datapath.
- Accepts WIDTH-bit words on a valid/ready input and emits them one bit per cycle on a valid/ready serial output.
- A one-word holding buffer lets consecutive words stream with no bubble between them.
- Shift direction is selectable, word boundaries are flagged, and a synchronous clear discards in-flight data.

Parameters:
- WIDTH, 4, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = emit bit WIDTH-1 first (shift left, zero fill); 0 = emit bit 0 first (shift right, zero fill).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- clear  input  1  synchronous flush; drops the active word and the held word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can take a word; in_ready = !hold_v (no combinational path from ser_ready).
- in_data  input  WIDTH  parallel word.
- ser_valid  output  1  ser_out valid; equals internal act.
- ser_ready  input  1  downstream consumes the bit this cycle.
- ser_out  output  1  current bit; forced 0 when !act.
- ser_first  output  1  act && cnt==0.
- ser_last  output  1  act && cnt==WIDTH-1.
- busy  output  1  act || hold_v.

Behaviour:
- State: shift register sh, counter cnt (clog2(WIDTH) bits), act flag, holding register hold, hold_v flag.
- Reset (rst_n=0 at an edge): sh=0, cnt=0, act=0, hold=0, hold_v=0.
  - Outputs after reset: ser_valid=0, ser_out=0, ser_first=0, ser_last=0, busy=0, in_ready=1.
  - Reset has priority over clear and over all handshakes.
  - Reset mid-word discards the word entirely; no partial-word output follows.
- clear=1 (rst_n=1): same register effect as reset. Any in_data accepted in the same cycle is discarded; clear wins.
- Cycle events: acc = in_valid && in_ready; fire = act && ser_ready; pop = fire && cnt==WIDTH-1.
- fire && !pop:
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0],0}.
  - MSB_FIRST=0: sh <= {0,sh[WIDTH-1:1]}.
  - cnt <= cnt+1.
- pop && hold_v: sh <= hold, cnt <= 0, act stays 1, hold_v <= 0. No bubble. acc cannot occur because in_ready=0.
- pop && !hold_v && acc: sh <= in_data, cnt <= 0, act stays 1. No bubble.
- pop && !hold_v && !acc: act <= 0, cnt <= 0.
- !pop && acc && !act: sh <= in_data, cnt <= 0, act <= 1.
  - Latency: word accepted at edge N shows its first bit with ser_valid=1 in the cycle after edge N.
- !pop && acc && act: hold <= in_data, hold_v <= 1.
- !fire: sh and cnt hold.
  - While ser_ready=0, ser_out, ser_first and ser_last stay stable.
  - ser_valid, once high, does not drop until the bit is consumed or clear/reset occurs.
- Throughput: with ser_ready tied 1 and in_valid tied 1, one bit every cycle indefinitely.
  - in_ready pulses so that one word is accepted per WIDTH cycles in steady state.
- Capacity: at most 2 words resident (active + hold). in_ready=0 exactly when hold is full.
- Outputs are functions of registered state only, except that the handshake gating uses the inputs ser_ready and in_valid.

Test Plan:
- WIDTH=4, MSB_FIRST=1, single word 4'b1011, ser_ready=1 -> ser_out 1,0,1,1 on 4 consecutive cycles starting the cycle after acceptance.
  - ser_first on bit 1, ser_last on bit 4; ser_valid=0 and busy=0 afterwards.
- Back-to-back 4'hB then 4'h6, in_valid held high, ser_ready=1 -> 8 contiguous valid bits 1,0,1,1,0,1,1,0 with no gap.
  - Second word enters hold while the first is active.
  - in_ready=0 until the first word's ser_last is consumed.
- Backpressure: word 4'b1011, ser_ready=0 for 3 cycles after bit 2 -> ser_out=0 held stable with ser_valid=1; cnt frozen.
  - Remaining bits 1,1 follow after ser_ready returns.
  - A third word offered while active+hold are full sees in_ready=0 and is not taken.
- MSB_FIRST=0, WIDTH=8, word 8'hA5 -> ser_out 1,0,1,0,0,1,0,1, with ser_last on the 8th bit.
- clear asserted on bit 3 of an active word with hold_v=1 and in_valid=1 -> next cycle ser_valid=0, busy=0, in_ready=1.
  - No bits from either discarded word appear later.
- rst_n=0 for 1 cycle mid-stream -> all outputs at reset values after the edge.
  - A new word 4'b0110 afterwards serialises cleanly as 0,1,1,0.
